// File: rtl/prescaler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prescaler_pkg
// Brief   : Shared types and limits for the multi-channel prescaler.
// Revision: 1.0 - initial release
// ============================================================================
package prescaler_pkg;

  // Per-channel counting mode, selected by the oneshot input bit
  typedef enum logic {
    PS_PERIODIC = 1'b0,
    PS_ONESHOT  = 1'b1
  } ps_mode_t;

  localparam int PS_MAX_WIDTH = 32;
  localparam int PS_MAX_NCH   = 8;

endpackage : prescaler_pkg
`default_nettype wire

// File: rtl/prescaler_chan.sv
`default_nettype none
// ============================================================================
// Module  : prescaler_chan
// Brief   : One down-counting prescaler channel with shadowed reload value,
//           periodic / one-shot mode and a sticky one-shot done flag.
// Revision: 1.0 - initial release
// ============================================================================
module prescaler_chan
  import prescaler_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk50m,
  input  logic             rst,
  input  logic             i_en,       // raw per-channel enable
  input  logic             i_gate,     // cascade gate from lower channels (1 when independent)
  input  logic             i_oneshot,
  input  logic [WIDTH-1:0] i_preval,
  input  logic             i_load,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_term,     // terminal count ignoring the cascade gate
  output logic             o_tick,
  output logic             o_done
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_shadow;
  logic             r_done;

  logic             w_eff_en;
  logic             w_term;
  logic             w_tick;
  ps_mode_t         w_mode;

  // Terminal-count decode; the gate is kept separate so the top can build the
  // cascade chain from o_term without a combinational loop through o_tick.
  always_comb begin
    w_mode   = ps_mode_t'(i_oneshot);
    w_term   = (r_cnt == '0) & i_en & ~r_done;
    w_tick   = w_term & i_gate;
    w_eff_en = i_en & i_gate & ~r_done;
  end

  // Counter, shadow and done update; start outranks tick, tick outranks decrement
  always_ff @(posedge clk50m) begin
    if (rst) begin
      r_cnt    <= '1;
      r_shadow <= '1;
      r_done   <= 1'b0;
    end else begin
      // A load lands at this edge, so any same-cycle reload still sees the old shadow
      if (i_load) begin
        r_shadow <= i_preval;
      end
      if (i_start) begin
        r_cnt  <= r_shadow;
        r_done <= 1'b0;
      end else if (w_tick) begin
        if (w_mode == PS_ONESHOT) begin
          r_done <= 1'b1;          // count stays parked at zero
        end else begin
          r_cnt  <= r_shadow;
        end
      end else if (w_eff_en) begin
        r_cnt <= r_cnt - 1'b1;     // never wraps: zero always ticks first
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_term = w_term;
  assign o_tick = w_tick;
  assign o_done = r_done;

endmodule : prescaler_chan
`default_nettype wire

// File: rtl/prescaler_multi.sv
`default_nettype none
// ============================================================================
// Module  : prescaler_multi
// Brief   : NCH independent (or cascaded) down-counting prescalers producing
//           tick enables for clk50m-domain consumers.
// Revision: 1.0 - initial release
// ============================================================================
module prescaler_multi
  import prescaler_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NCH     = 2,
  parameter int CASCADE = 0
) (
  input  logic                      clk50m,
  input  logic                      rst,
  input  logic [NCH-1:0]            en,
  input  logic [NCH-1:0]            oneshot,
  input  logic [NCH-1:0][WIDTH-1:0] preval,
  input  logic [NCH-1:0]            load,
  input  logic [NCH-1:0]            start,
  output logic [NCH-1:0][WIDTH-1:0] cnt,
  output logic [NCH-1:0]            tick,
  output logic [NCH-1:0]            done
);

  // Elaboration-time range checks
  generate
    if (WIDTH < 2 || WIDTH > PS_MAX_WIDTH) begin : g_bad_width
      $error("prescaler_multi: WIDTH out of range 2..32");
    end
    if (NCH < 1 || NCH > PS_MAX_NCH) begin : g_bad_nch
      $error("prescaler_multi: NCH out of range 1..8");
    end
  endgenerate

  logic [NCH-1:0] w_term;
  logic [NCH-1:0] w_gate;

  // Cascade gate: channel k may count only while every lower channel is at its
  // terminal count, i.e. tick[k-1] is high. Built as a running AND of o_term.
  always_comb begin
    logic w_acc;
    w_gate = '1;
    w_acc  = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (CASCADE != 0) begin
        w_gate[k] = w_acc;
      end
      w_acc = w_acc & w_term[k];
    end
  end

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_ch
      prescaler_chan #(
        .WIDTH (WIDTH)
      ) u_chan (
        .clk50m    (clk50m),
        .rst       (rst),
        .i_en      (en[k]),
        .i_gate    (w_gate[k]),
        .i_oneshot (oneshot[k]),
        .i_preval  (preval[k]),
        .i_load    (load[k]),
        .i_start   (start[k]),
        .o_cnt     (cnt[k]),
        .o_term    (w_term[k]),
        .o_tick    (tick[k]),
        .o_done    (done[k])
      );
    end
  endgenerate

endmodule : prescaler_multi
`default_nettype wire

// File: tb/tb_prescaler_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_prescaler_multi
// Brief   : Directed bench for prescaler_multi; an independent instance and a
//           cascaded instance share one stimulus stream and one reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_prescaler_multi;

  localparam int W    = 8;
  localparam int N    = 2;
  localparam int MASK = (1 << W) - 1;

  logic                  clk50m = 1'b0;
  logic                  rst;
  logic [N-1:0]          en, oneshot, load, start;
  logic [N-1:0][W-1:0]   preval;
  logic [N-1:0][W-1:0]   a_cnt, b_cnt;
  logic [N-1:0]          a_tick, a_done, b_tick, b_done;

  int total = 0;
  int bad   = 0;

  always #10 clk50m = ~clk50m;

  prescaler_multi #(.WIDTH(W), .NCH(N), .CASCADE(0)) u_dut_a (
    .clk50m(clk50m), .rst(rst), .en(en), .oneshot(oneshot), .preval(preval),
    .load(load), .start(start), .cnt(a_cnt), .tick(a_tick), .done(a_done)
  );

  prescaler_multi #(.WIDTH(W), .NCH(N), .CASCADE(1)) u_dut_b (
    .clk50m(clk50m), .rst(rst), .en(en), .oneshot(oneshot), .preval(preval),
    .load(load), .start(start), .cnt(b_cnt), .tick(b_tick), .done(b_done)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = independent instance, 1 = cascaded instance
  int m_cnt [2][N];
  int m_sh  [2][N];
  bit m_done[2][N];
  bit m_valid = 1'b0;

  // Compare every cycle at the falling edge, then advance the model using the
  // inputs that will be sampled at the coming rising edge.
  always @(negedge clk50m) begin : compare
    bit t[N];
    bit prev;
    for (int d = 0; d < 2; d++) begin
      prev = 1'b1;
      for (int k = 0; k < N; k++) begin
        t[k] = (m_cnt[d][k] == 0) && en[k] && !m_done[d][k] && (d == 0 || k == 0 || prev);
        prev = t[k];
      end
      if (m_valid) begin
        for (int k = 0; k < N; k++) begin
          chk($sformatf("model_cnt d%0d ch%0d", d, k),
              int'(d == 0 ? a_cnt[k] : b_cnt[k]), m_cnt[d][k]);
          chk($sformatf("model_tick d%0d ch%0d", d, k),
              int'(d == 0 ? a_tick[k] : b_tick[k]), int'(t[k]));
          chk($sformatf("model_done d%0d ch%0d", d, k),
              int'(d == 0 ? a_done[k] : b_done[k]), int'(m_done[d][k]));
        end
      end
      for (int k = 0; k < N; k++) begin
        if (rst) begin
          m_cnt[d][k]  = MASK;
          m_sh[d][k]   = MASK;
          m_done[d][k] = 1'b0;
        end else begin
          bit running;
          running = en[k] && !m_done[d][k] && (d == 0 || k == 0 || t[k-1]);
          if (start[k]) begin
            m_cnt[d][k]  = m_sh[d][k];
            m_done[d][k] = 1'b0;
          end else if (t[k] && oneshot[k]) begin
            m_done[d][k] = 1'b1;
          end else if (t[k]) begin
            m_cnt[d][k] = m_sh[d][k];
          end else if (running) begin
            m_cnt[d][k] = (m_cnt[d][k] - 1) & MASK;
          end
          if (load[k]) m_sh[d][k] = int'(preval[k]);
        end
      end
    end
    if (rst) m_valid = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk50m);
      #1;
    end
  endtask

  // Count cycles (the current one is cycle 1) until the selected tick is seen;
  // n = -1 when no tick appears within maxc cycles. Leaves at posedge+1.
  task automatic wait_tick(input int sel, input int ch, input int maxc, output int n);
    n = -1;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk50m);
      if ((sel == 0 ? a_tick[ch] : b_tick[ch]) === 1'b1) begin
        n = c;
        break;
      end
    end
    @(posedge clk50m);
    #1;
  endtask

  initial begin : stim
    int n;
    rst = 1'b1; en = '0; oneshot = '0; load = '0; start = '0; preval = '0;
    step(2);
    @(negedge clk50m);
    chk("reset_cnt", int'(a_cnt[0]), 255);
    chk("reset_tick", int'(a_tick), 0);
    chk("reset_done", int'(a_done), 0);
    @(posedge clk50m); #1;

    // 1: first tick 256 cycles after reset, then period 256
    rst = 1'b0; en = 2'b01;
    wait_tick(0, 0, 300, n); chk("t1_first_tick", n, 256);
    wait_tick(0, 0, 300, n); chk("t1_period", n, 256);

    // 2: shadow written mid-period does not disturb the in-flight period
    preval[0] = 8'd5; load = 2'b01; step(1);
    load = 2'b00; start = 2'b01; step(1);
    start = 2'b00; step(3);
    preval[0] = 8'd3; load = 2'b01;
    @(negedge clk50m); chk("t2_cnt_at_load", int'(a_cnt[0]), 2);
    @(posedge clk50m); #1;
    load = 2'b00;
    wait_tick(0, 0, 20, n); chk("t2_inflight", n, 2);
    wait_tick(0, 0, 20, n); chk("t2_period_a", n, 4);
    wait_tick(0, 0, 20, n); chk("t2_period_b", n, 4);

    // 3: one-shot fires once after 6 cycles, parks at 0, rearmed by start
    oneshot = 2'b01; preval[0] = 8'd5; load = 2'b01; step(1);
    load = 2'b00; start = 2'b01; step(1);
    start = 2'b00;
    wait_tick(0, 0, 20, n); chk("t3_oneshot", n, 6);
    @(negedge clk50m);
    chk("t3_done", int'(a_done[0]), 1);
    chk("t3_cnt_parked", int'(a_cnt[0]), 0);
    @(posedge clk50m); #1;
    wait_tick(0, 0, 10, n); chk("t3_no_retick", n, -1);
    start = 2'b01; step(1);
    start = 2'b00;
    @(negedge clk50m);
    chk("t3_done_cleared", int'(a_done[0]), 0);
    chk("t3_cnt_rearmed", int'(a_cnt[0]), 5);
    @(posedge clk50m); #1;
    wait_tick(0, 0, 20, n); chk("t3_second_shot", n, 5);

    // 4: start + load(9) in the tick cycle reload from the old shadow (4)
    oneshot = 2'b00;
    @(negedge clk50m); chk("t4_done_sticky", int'(a_done[0]), 1);
    @(posedge clk50m); #1;
    preval[0] = 8'd4; load = 2'b01; step(1);
    load = 2'b00; start = 2'b01; step(1);
    start = 2'b00; step(4);
    start = 2'b01; load = 2'b01; preval[0] = 8'd9;
    @(negedge clk50m); chk("t4_tick_with_start", int'(a_tick[0]), 1);
    @(posedge clk50m); #1;
    start = 2'b00; load = 2'b00;
    @(negedge clk50m); chk("t4_old_shadow", int'(a_cnt[0]), 4);
    @(posedge clk50m); #1;
    wait_tick(0, 0, 20, n); chk("t4_rest", n, 4);
    wait_tick(0, 0, 20, n); chk("t4_new_period", n, 10);

    // 6: en=0 holds; mid-count reset restores count and shadow to all ones
    en = 2'b00; step(3);
    @(negedge clk50m); chk("t6_hold", int'(a_cnt[0]), 9);
    @(posedge clk50m); #1;
    en = 2'b01; step(2);
    rst = 1'b1; step(1);
    rst = 1'b0;
    @(negedge clk50m);
    chk("t6_rst_cnt", int'(a_cnt[0]), 255);
    chk("t6_rst_tick", int'(a_tick[0]), 0);
    chk("t6_rst_done", int'(a_done[0]), 0);
    @(posedge clk50m); #1;
    start = 2'b01; step(1);
    start = 2'b00;
    @(negedge clk50m); chk("t6_rst_shadow", int'(a_cnt[0]), 255);
    @(posedge clk50m); #1;

    // 5: cascade, shadow0=1, shadow1=2 -> tick[1] every (1+1)*(2+1)=6 cycles
    preval = {8'd2, 8'd1}; load = 2'b11; step(1);
    load = 2'b00; start = 2'b11; step(1);
    start = 2'b00; en = 2'b11;
    wait_tick(1, 1, 30, n); chk("t5_cascade_first", n, 6);
    wait_tick(1, 1, 30, n); chk("t5_cascade_period", n, 6);
    wait_tick(1, 0, 30, n); chk("t5_ch0_period", n, 2);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_prescaler_multi
`default_nettype wire
